// File: rtl/multicycle_control_unit.sv
// Main control FSM and ALU/immediate decoder for the riscv32i multicycle core.
// Latency: 3-5 cycles per instruction (beq 3, sw/R/I/jal 4, lw 5); outputs are Moore except PCWrite in S_BEQ.
// Backpressure: none; the datapath follows the sequence unconditionally. Optional macro CTRL_BNE_EN adds bne.

package mcu_pkg;

  typedef enum logic {
    ADR_PC     = 1'b0,
    ADR_RESULT = 1'b1
  } AdrSrc_t;

  typedef enum logic [1:0] {
    ALU_PC     = 2'd0,
    ALU_OLD_PC = 2'd1,
    ALU_RD1    = 2'd2
  } ALUSrcA_t;

  typedef enum logic [1:0] {
    ALU_RD2    = 2'd0,
    ALU_EXTEND = 2'd1,
    ALU_PLUS_4 = 2'd2
  } ALUsource_t;

  typedef enum logic [1:0] {
    RESULT_FROM_ALU = 2'd0,
    RESULT_FROM_MEM = 2'd1,
    RESULT_FROM_PC4 = 2'd2
  } ResultSource_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLT = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } ALUop_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } IMM_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

endpackage

module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrc,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal
);

  // Coarse ALU request from the FSM; OP_FUNCT defers to the funct3/funct7 decoder.
  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_FUNCT = 2'd2
  } alu_req_t;

  state_t        state;
  state_t        state_nxt;
  alu_req_t      alu_req;
  ALUop_t        alu_control;
  IMM_t          imm_src;
  AdrSrc_t       adr_src;
  ALUSrcA_t      alu_src_a;
  ALUsource_t    alu_src;
  ResultSource_t result_src;
  logic          reg_write;
  logic          ir_write;
  logic          pc_write;
  logic          mem_write;
  logic          illegal_op;
  logic          branch_taken;

  // Only funct7[5] distinguishes sub from add; the rest of funct7 is don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register; reset abandons any in-flight instruction and restarts at fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Branch resolution from the live zero flag; only beq (and bne when enabled) can redirect the PC.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
`ifdef CTRL_BNE_EN
      3'b001:  branch_taken = ~zero;
`else
      3'b001:  branch_taken = 1'b0;
`endif
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and Moore control decode; any unused encoding falls back to fetch.
  always_comb begin
    state_nxt  = S_FETCH;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    adr_src    = ADR_PC;
    alu_src_a  = ALU_RD1;
    alu_src    = ALU_RD2;
    result_src = RESULT_FROM_ALU;
    alu_req    = OP_ADD;

    case (state)
      S_FETCH: begin
        // PC+4 goes straight back into the PC while the instruction is latched.
        adr_src    = ADR_PC;
        ir_write   = 1'b1;
        alu_src_a  = ALU_PC;
        alu_src    = ALU_PLUS_4;
        alu_req    = OP_ADD;
        result_src = RESULT_FROM_PC4;
        pc_write   = 1'b1;
        state_nxt  = S_DECODE;
      end

      S_DECODE: begin
        // Compute OldPC+imm speculatively so ALUOut holds the branch/jump target.
        alu_src_a = ALU_OLD_PC;
        alu_src   = ALU_EXTEND;
        alu_req   = OP_ADD;
        case (opcode)
          OPC_LW, OPC_SW: state_nxt = S_MEMADR;
          OPC_R:          state_nxt = S_EXEC_R;
          OPC_I:          state_nxt = S_EXEC_I;
          OPC_BR:         state_nxt = S_BEQ;
          OPC_JAL:        state_nxt = S_JAL;
          default: begin
            state_nxt  = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = ALU_RD1;
        alu_src   = ALU_EXTEND;
        alu_req   = OP_ADD;
        state_nxt = (opcode == OPC_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        adr_src    = ADR_RESULT;
        result_src = RESULT_FROM_ALU;
        state_nxt  = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = RESULT_FROM_MEM;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEMWRITE: begin
        adr_src    = ADR_RESULT;
        result_src = RESULT_FROM_ALU;
        mem_write  = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = ALU_RD1;
        alu_src   = ALU_RD2;
        alu_req   = OP_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_a = ALU_RD1;
        alu_src   = ALU_EXTEND;
        alu_req   = OP_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = RESULT_FROM_ALU;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_BEQ: begin
        // The compare runs this cycle while ResultSrc routes the decode-time target to the PC.
        alu_src_a  = ALU_RD1;
        alu_src    = ALU_RD2;
        alu_req    = OP_SUB;
        result_src = RESULT_FROM_ALU;
        pc_write   = branch_taken;
        state_nxt  = S_FETCH;
      end

      S_JAL: begin
        // Jump to the decode-time target while the ALU forms OldPC+4 for the link write.
        alu_src_a  = ALU_OLD_PC;
        alu_src    = ALU_PLUS_4;
        alu_req    = OP_ADD;
        result_src = RESULT_FROM_ALU;
        pc_write   = 1'b1;
        state_nxt  = S_ALUWB;
      end

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // ALU operation decode; addi never subtracts regardless of funct7.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_req)
      OP_SUB: alu_control = ALU_SUB;
      OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = ((opcode == OPC_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode in every state so the extender is always primed.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OPC_LW, OPC_I: imm_src = IMM_I;
      OPC_SW:        imm_src = IMM_S;
      OPC_BR:        imm_src = IMM_B;
      OPC_JAL:       imm_src = IMM_J;
      default:       imm_src = IMM_I;
    endcase
  end

  // Enables are squashed combinationally while reset is held so a store cannot linger.
  assign RegWrite   = reg_write  & rst;
  assign IRWrite    = ir_write   & rst;
  assign PCWrite    = pc_write   & rst;
  assign MemWrite   = mem_write  & rst;
  assign illegal    = illegal_op & rst;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrc     = alu_src;
  assign ResultSrc  = result_src;
  assign ALUControl = alu_control;
  assign ImmSrc     = imm_src;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: instruction table expanded into per-cycle expectations.
// Expected output vectors are queued per instruction and popped/compared every cycle.
// Extra hand sequences cover the Mealy branch flag and reset during a store.

module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrc, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_control_unit #(.RESET_STATE(S_FETCH)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zero(zero),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal;
  } out_t;

  // Instruction classes and the cycle-by-cycle step names they walk through.
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;
  localparam int T_F = 0, T_D = 1, T_MA = 2, T_MR = 3, T_MWB = 4, T_MW = 5;
  localparam int T_ER = 6, T_EI = 7, T_AWB = 8, T_BQ = 9, T_J = 10;

  typedef struct {
    string      name;
    int         cls;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       br;
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, int cls, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                              logic z, logic [2:0] alu, logic [1:0] imm, logic br, logic ill);
    vec_t v;
    v.name = name; v.cls = cls; v.opc = opc; v.f3 = f3; v.f7 = f7; v.z = z;
    v.alu = alu; v.imm = imm; v.br = br; v.ill = ill;
    return v;
  endfunction

  function automatic int n_steps(int cls);
    case (cls)
      C_LW:         return 5;
      C_BR:         return 3;
      C_ILL:        return 2;
      default:      return 4;
    endcase
  endfunction

  function automatic int step_at(int cls, int i);
    int seq[5];
    case (cls)
      C_LW:    seq = '{T_F, T_D, T_MA, T_MR, T_MWB};
      C_SW:    seq = '{T_F, T_D, T_MA, T_MW, T_F};
      C_R:     seq = '{T_F, T_D, T_ER, T_AWB, T_F};
      C_I:     seq = '{T_F, T_D, T_EI, T_AWB, T_F};
      C_BR:    seq = '{T_F, T_D, T_BQ, T_F, T_F};
      C_JAL:   seq = '{T_F, T_D, T_J, T_AWB, T_F};
      default: seq = '{T_F, T_D, T_F, T_F, T_F};
    endcase
    return seq[i];
  endfunction

  // Expected control word for one step of an instruction, written out from the state table.
  function automatic out_t exp_step(int st, vec_t v);
    out_t o;
    o = '0;
    o.adr_src     = ADR_PC;
    o.alu_src_a   = ALU_RD1;
    o.alu_src     = ALU_RD2;
    o.result_src  = RESULT_FROM_ALU;
    o.alu_control = ALU_ADD;
    o.imm_src     = v.imm;
    case (st)
      T_F:   begin o.ir_write = 1; o.pc_write = 1; o.alu_src_a = ALU_PC;
                   o.alu_src = ALU_PLUS_4; o.result_src = RESULT_FROM_PC4; end
      T_D:   begin o.alu_src_a = ALU_OLD_PC; o.alu_src = ALU_EXTEND; o.illegal = v.ill; end
      T_MA:  begin o.alu_src = ALU_EXTEND; end
      T_MR:  begin o.adr_src = ADR_RESULT; end
      T_MWB: begin o.result_src = RESULT_FROM_MEM; o.reg_write = 1; end
      T_MW:  begin o.adr_src = ADR_RESULT; o.mem_write = 1; end
      T_ER:  begin o.alu_control = v.alu; end
      T_EI:  begin o.alu_src = ALU_EXTEND; o.alu_control = v.alu; end
      T_AWB: begin o.reg_write = 1; end
      T_BQ:  begin o.alu_control = ALU_SUB; o.pc_write = v.br; end
      T_J:   begin o.alu_src_a = ALU_OLD_PC; o.alu_src = ALU_PLUS_4; o.pc_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // While reset is held: fetch-state muxes, every enable low.
  function automatic out_t rst_exp(vec_t v);
    out_t o;
    o = exp_step(T_F, v);
    o.ir_write = 0;
    o.pc_write = 0;
    return o;
  endfunction

  task automatic check_now(string name);
    out_t act;
    out_t exp;
    act = '{RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrc, ResultSrc,
            ALUControl, ImmSrc, illegal};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    opcode = v.opc;
    funct3 = v.f3;
    funct7 = v.f7;
    zero   = v.z;
  endtask

  // Called just after a falling edge with the DUT in fetch; ends on the falling edge after the last step.
  task automatic run_instr(vec_t v);
    int n;
    n = n_steps(v.cls);
    drive(v);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_step(step_at(v.cls, i), v));
    for (int i = 0; i < n; i++) begin
      #1;
      check_now($sformatf("%s_c%0d", v.name, i + 1));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vec_t sw_v;
    vec_t beq_v;
    logic bne_z0;

`ifdef CTRL_BNE_EN
    bne_z0 = 1'b1;
`else
    bne_z0 = 1'b0;
`endif

    //        name        cls    opcode       f3      f7           z  alu      imm    br      ill
    vecs.push_back(mk("lw",   C_LW,  7'b0000011, 3'b010, 7'b0000000, 0, ALU_ADD, IMM_I, 0,      0));
    vecs.push_back(mk("sw",   C_SW,  7'b0100011, 3'b010, 7'b0000000, 0, ALU_ADD, IMM_S, 0,      0));
    vecs.push_back(mk("sub",  C_R,   7'b0110011, 3'b000, 7'b0100000, 0, ALU_SUB, IMM_I, 0,      0));
    vecs.push_back(mk("add",  C_R,   7'b0110011, 3'b000, 7'b0000000, 0, ALU_ADD, IMM_I, 0,      0));
    vecs.push_back(mk("slt",  C_R,   7'b0110011, 3'b010, 7'b0000000, 0, ALU_SLT, IMM_I, 0,      0));
    vecs.push_back(mk("or",   C_R,   7'b0110011, 3'b110, 7'b0000000, 0, ALU_OR,  IMM_I, 0,      0));
    vecs.push_back(mk("and",  C_R,   7'b0110011, 3'b111, 7'b0000000, 0, ALU_AND, IMM_I, 0,      0));
    vecs.push_back(mk("xor",  C_R,   7'b0110011, 3'b100, 7'b0000000, 0, ALU_ADD, IMM_I, 0,      0));
    vecs.push_back(mk("addi", C_I,   7'b0010011, 3'b000, 7'b0100000, 0, ALU_ADD, IMM_I, 0,      0));
    vecs.push_back(mk("slti", C_I,   7'b0010011, 3'b010, 7'b0000000, 0, ALU_SLT, IMM_I, 0,      0));
    vecs.push_back(mk("ori",  C_I,   7'b0010011, 3'b110, 7'b0000000, 0, ALU_OR,  IMM_I, 0,      0));
    vecs.push_back(mk("andi", C_I,   7'b0010011, 3'b111, 7'b0000000, 0, ALU_AND, IMM_I, 0,      0));
    vecs.push_back(mk("beq1", C_BR,  7'b1100011, 3'b000, 7'b0000000, 1, ALU_ADD, IMM_B, 1,      0));
    vecs.push_back(mk("beq0", C_BR,  7'b1100011, 3'b000, 7'b0000000, 0, ALU_ADD, IMM_B, 0,      0));
    vecs.push_back(mk("bne0", C_BR,  7'b1100011, 3'b001, 7'b0000000, 0, ALU_ADD, IMM_B, bne_z0, 0));
    vecs.push_back(mk("bne1", C_BR,  7'b1100011, 3'b001, 7'b0000000, 1, ALU_ADD, IMM_B, 0,      0));
    vecs.push_back(mk("blt1", C_BR,  7'b1100011, 3'b100, 7'b0000000, 1, ALU_ADD, IMM_B, 0,      0));
    vecs.push_back(mk("jal",  C_JAL, 7'b1101111, 3'b000, 7'b0000000, 0, ALU_ADD, IMM_J, 0,      0));
    vecs.push_back(mk("ill7f",C_ILL, 7'b1111111, 3'b000, 7'b0000000, 0, ALU_ADD, IMM_I, 0,      1));
    vecs.push_back(mk("lui",  C_ILL, 7'b0110111, 3'b000, 7'b0000000, 0, ALU_ADD, IMM_I, 0,      1));
    vecs.push_back(mk("lw2",  C_LW,  7'b0000011, 3'b010, 7'b0000000, 1, ALU_ADD, IMM_I, 0,      0));

    // Reset held for three cycles with a store on the opcode bus.
    rst = 1'b0;
    drive(vecs[1]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      exp_q.push_back(rst_exp(vecs[1]));
      check_now($sformatf("reset_c%0d", i + 1));
    end
    @(negedge clk);
    rst = 1'b1;

    // Table: each instruction returns to fetch, which the next entry's first cycle confirms.
    foreach (vecs[k]) run_instr(vecs[k]);

    // beq with zero changing inside the compare cycle: PCWrite follows it immediately.
    beq_v = vecs[13];
    drive(beq_v);
    exp_q.push_back(exp_step(T_F, beq_v));
    exp_q.push_back(exp_step(T_D, beq_v));
    for (int i = 0; i < 2; i++) begin
      #1;
      check_now($sformatf("beq_mealy_c%0d", i + 1));
      @(negedge clk);
    end
    #1;
    exp_q.push_back(exp_step(T_BQ, beq_v));
    check_now("beq_mealy_z0");
    zero = 1'b1;
    v = beq_v;
    v.br = 1'b1;
    #1;
    exp_q.push_back(exp_step(T_BQ, v));
    check_now("beq_mealy_z1");
    @(negedge clk);

    // Store interrupted by reset in the write cycle.
    sw_v = vecs[1];
    drive(sw_v);
    exp_q.push_back(exp_step(T_F, sw_v));
    exp_q.push_back(exp_step(T_D, sw_v));
    exp_q.push_back(exp_step(T_MA, sw_v));
    exp_q.push_back(exp_step(T_MW, sw_v));
    for (int i = 0; i < 4; i++) begin
      #1;
      check_now($sformatf("sw_rst_c%0d", i + 1));
      if (i < 3) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    exp_q.push_back(rst_exp(sw_v));
    check_now("sw_rst_drop");
    @(negedge clk);
    #1;
    exp_q.push_back(rst_exp(sw_v));
    check_now("sw_rst_hold");
    rst = 1'b1;
    // First cycle after release must be a clean fetch of a fresh instruction.
    run_instr(vecs[17]);
    run_instr(vecs[0]);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d queued expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
